// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand-forwarding and load-use hazard control for the
// EX-stage operand muxes of a 5-stage pipeline. Keeps a short shadow of the
// in-flight register writes (EX, MEM, WB) and decides, per source operand,
// whether ID must stall and which mux input EX should use.
module fwd_hazard_unit #(
  parameter int unsigned REG_AW = 5,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        ex_fwd_a_sel,
  output logic [1:0]        ex_fwd_b_sel,
  output logic              ex_valid,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd
);

  // Operand mux select encoding; 3 is never produced.
  localparam logic [1:0] SEL_REGFILE = 2'd0;
  localparam logic [1:0] SEL_EX_MEM  = 2'd1;
  localparam logic [1:0] SEL_MEM_WB  = 2'd2;

  // The EX slot is the only one whose load flag matters (load-use check).
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              load;
  } ex_slot_t;

  ex_slot_t          ex_q;
  logic              mem_valid_q;
  logic [REG_AW-1:0] mem_rd_q;
  logic              mem_wr_q;
  logic              wb_valid_q;
  logic [REG_AW-1:0] wb_rd_q;
  logic [1:0]        sel_a_q;
  logic [1:0]        sel_b_q;

  logic              ex_prod;
  logic              mem_prod;
  logic              rs_read;
  logic              rt_read;
  logic              a_ex;
  logic              a_mem;
  logic              b_ex;
  logic              b_mem;
  logic              raw_stall;
  logic [1:0]        sel_a_d;
  logic [1:0]        sel_b_d;

  // A slot produces a value only if it is a real write to a non-zero register.
  assign ex_prod  = ex_q.valid & ex_q.wr & (ex_q.rd != '0);
  assign mem_prod = mem_valid_q & mem_wr_q & (mem_rd_q != '0);

  // r0 is hard-wired, so reading it never creates a dependency.
  assign rs_read  = id_valid & id_use_rs & (id_rs != '0);
  assign rt_read  = id_valid & id_use_rt & (id_rt != '0);

  assign a_ex     = rs_read & ex_prod  & (ex_q.rd  == id_rs);
  assign a_mem    = rs_read & mem_prod & (mem_rd_q == id_rs);
  assign b_ex     = rt_read & ex_prod  & (ex_q.rd  == id_rt);
  assign b_mem    = rt_read & mem_prod & (mem_rd_q == id_rt);

  // Hazard detection: a load in EX has no result to forward yet; without
  // forwarding every pending EX/MEM write to a source has to drain first.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so no path leaves it unassigned and no latch is inferred.
    raw_stall = 1'b0;
    if (FWD_EN) begin
      raw_stall = (a_ex | b_ex) & ex_q.load;
    end else begin
      raw_stall = a_ex | a_mem | b_ex | b_mem;
    end
  end

  // A taken branch kills the ID instruction, so its hazard is irrelevant.
  assign stall = raw_stall & ~flush;

  // Next operand selects: the youngest producer (EX) beats the older (MEM);
  // a WB match needs nothing because the regfile is write-first.
  always_comb begin
    sel_a_d = SEL_REGFILE;
    sel_b_d = SEL_REGFILE;
    if (FWD_EN) begin
      if (a_ex) begin
        sel_a_d = SEL_EX_MEM;
      end else if (a_mem) begin
        sel_a_d = SEL_MEM_WB;
      end
      if (b_ex) begin
        sel_b_d = SEL_EX_MEM;
      end else if (b_mem) begin
        sel_b_d = SEL_MEM_WB;
      end
    end
  end

  // Slot advance: MEM and WB always move; EX takes the ID instruction or a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this state is a handful of control flops, not a storage array, so every bit is reset.
      ex_q        <= '0;
      mem_valid_q <= 1'b0;
      mem_rd_q    <= '0;
      mem_wr_q    <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      sel_a_q     <= SEL_REGFILE;
      sel_b_q     <= SEL_REGFILE;
    end else begin
      // NOTE: non-blocking assignments so each slot captures its neighbour's pre-edge value.
      wb_valid_q  <= mem_valid_q & mem_wr_q;
      wb_rd_q     <= mem_rd_q;
      mem_valid_q <= ex_q.valid;
      mem_rd_q    <= ex_q.rd;
      mem_wr_q    <= ex_q.wr;
      if (flush || stall) begin
        ex_q    <= '0;
        sel_a_q <= SEL_REGFILE;
        sel_b_q <= SEL_REGFILE;
      end else begin
        ex_q    <= '{valid: id_valid, rd: id_rd, wr: id_reg_write, load: id_is_load};
        sel_a_q <= sel_a_d;
        sel_b_q <= sel_b_d;
      end
    end
  end

  assign ex_fwd_a_sel = sel_a_q;
  assign ex_fwd_b_sel = sel_b_q;
  assign ex_valid     = ex_q.valid;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: drives one forwarding instance and one non-forwarding
// instance with the same ID stream, compares both against a history model
// every cycle, and pins key moments with hand-computed literals.
module tb_fwd_hazard_unit;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_is_load;
  logic       flush;

  // Index 1 = FWD_EN=1 instance, index 0 = FWD_EN=0 instance.
  logic [1:0] stall_v;
  logic [1:0] exv_v;
  logic [1:0] wbv_v;
  logic [1:0] sa_v [2];
  logic [1:0] sb_v [2];
  logic [4:0] wbrd_v [2];

  int total = 0;
  int bad   = 0;

  fwd_hazard_unit #(.REG_AW(5), .FWD_EN(1'b1)) dut_fwd (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush),
    .stall(stall_v[1]), .ex_fwd_a_sel(sa_v[1]), .ex_fwd_b_sel(sb_v[1]),
    .ex_valid(exv_v[1]), .wb_valid(wbv_v[1]), .wb_rd(wbrd_v[1])
  );

  fwd_hazard_unit #(.REG_AW(5), .FWD_EN(1'b0)) dut_nofwd (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush),
    .stall(stall_v[0]), .ex_fwd_a_sel(sa_v[0]), .ex_fwd_b_sel(sb_v[0]),
    .ex_valid(exv_v[0]), .wb_valid(wbv_v[0]), .wb_rd(wbrd_v[0])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // History of instructions that entered EX, by age: 0 = in EX, 1 = in MEM,
  // 2 = in WB. Bubbles are all-zero records.
  typedef struct packed {
    bit       v;
    bit [4:0] rd;
    bit       wr;
    bit       ld;
  } instr_t;

  instr_t   hist [2][3];
  bit [1:0] exp_sa [2];
  bit [1:0] exp_sb [2];

  // Does the ID operand x depend on the instruction of the given age?
  function automatic bit hit(input int d, input int age, input bit use_x, input bit [4:0] x);
    instr_t p;
    p = hist[d][age];
    return id_valid && use_x && (x != 0) && p.v && p.wr && (p.rd == x);
  endfunction

  function automatic bit m_stall(input int d);
    bit dep_ex;
    bit dep_mem;
    if (flush) return 1'b0;
    dep_ex  = hit(d, 0, id_use_rs, id_rs) || hit(d, 0, id_use_rt, id_rt);
    dep_mem = hit(d, 1, id_use_rs, id_rs) || hit(d, 1, id_use_rt, id_rt);
    if (d == 1) return dep_ex && hist[d][0].ld;
    return dep_ex || dep_mem;
  endfunction

  function automatic bit [1:0] m_sel(input int d, input bit use_x, input bit [4:0] x);
    if (d == 0) return 2'd0;
    if (hit(d, 0, use_x, x)) return 2'd1;
    if (hit(d, 1, use_x, x)) return 2'd2;
    return 2'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model_upd
    bit       acc;
    bit [1:0] na;
    bit [1:0] nb;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        for (int a = 0; a < 3; a++) hist[d][a] = '0;
        exp_sa[d] = 2'd0;
        exp_sb[d] = 2'd0;
      end else begin
        acc = !flush && !m_stall(d);
        na  = acc ? m_sel(d, id_use_rs, id_rs) : 2'd0;
        nb  = acc ? m_sel(d, id_use_rt, id_rt) : 2'd0;
        hist[d][2] = hist[d][1];
        hist[d][1] = hist[d][0];
        hist[d][0] = acc ? instr_t'{v: id_valid, rd: id_rd, wr: id_reg_write, ld: id_is_load} : '0;
        exp_sa[d] = na;
        exp_sb[d] = nb;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      check($sformatf("model_stall[m%0d]", d), stall_v[d], m_stall(d));
      check($sformatf("model_sel_a[m%0d]", d), sa_v[d], exp_sa[d]);
      check($sformatf("model_sel_b[m%0d]", d), sb_v[d], exp_sb[d]);
      check($sformatf("model_ex_valid[m%0d]", d), exv_v[d], hist[d][0].v);
      check($sformatf("model_wb_valid[m%0d]", d), wbv_v[d], hist[d][2].v && hist[d][2].wr);
      check($sformatf("model_wb_rd[m%0d]", d), wbrd_v[d], hist[d][2].rd);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit urs,
                     input bit urt, input bit [4:0] rd, input bit wr, input bit ld, input bit fl);
    id_valid     = v;
    id_rs        = rs;
    id_rt        = rt;
    id_use_rs    = urs;
    id_use_rt    = urt;
    id_rd        = rd;
    id_reg_write = wr;
    id_is_load   = ld;
    flush        = fl;
    @(negedge clk);
  endtask

  task automatic nop();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held while ID shows a real reader of r3.
    rst_n = 1'b0;
    drv(1, 3, 0, 1, 0, 3, 1, 0, 0); adv(); adv();
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_stall", stall_v[1], 0);
    check("reset_sel_a", sa_v[1], 0);
    check("reset_sel_b", sb_v[1], 0);
    check("reset_ex_valid", exv_v[1], 0);
    check("reset_wb_valid", wbv_v[1], 0);
    adv();

    // EX->EX forward on both operands of the same register.
    drv(1, 0, 0, 0, 0, 5, 1, 0, 0); adv();              // add r5
    drv(1, 5, 5, 1, 1, 6, 1, 0, 0);                     // sub r6, r5, r5
    check("exfwd_no_stall", stall_v[1], 0);
    adv();
    nop();
    check("exfwd_sel_a", sa_v[1], 1);
    check("exfwd_sel_b", sb_v[1], 1);
    check("exfwd_ex_valid", exv_v[1], 1);
    adv();

    // Writer of r0 never forwards.
    drv(1, 0, 0, 0, 0, 0, 1, 0, 0); adv();              // add r0
    drv(1, 0, 0, 1, 1, 6, 1, 0, 0); adv();              // reader of r0
    nop();
    check("r0_sel_a", sa_v[1], 0);
    check("r0_sel_b", sb_v[1], 0);
    adv();

    // Two-back forward from MEM.
    drv(1, 0, 0, 0, 0, 4, 1, 0, 0); adv();              // add r4
    nop(); adv();
    drv(1, 4, 0, 1, 0, 8, 1, 0, 0); adv();              // or r8, r4
    nop();
    check("memfwd_sel_a", sa_v[1], 2);
    adv();

    // Two writers of r4: the younger one wins.
    drv(1, 0, 0, 0, 0, 4, 1, 0, 0); adv();
    drv(1, 0, 0, 0, 0, 4, 1, 0, 0); adv();
    drv(1, 4, 0, 1, 0, 8, 1, 0, 0); adv();
    nop();
    check("prio_sel_a", sa_v[1], 1);
    adv();

    // Load-use: one bubble, then MEM forward on operand B.
    drv(1, 0, 0, 0, 0, 7, 1, 1, 0); adv();              // lw r7
    drv(1, 1, 7, 1, 1, 9, 1, 0, 0);                     // add r9, r1, r7
    check("lu_stall", stall_v[1], 1);
    adv();
    drv(1, 1, 7, 1, 1, 9, 1, 0, 0);                     // held in ID
    check("lu_released", stall_v[1], 0);
    check("lu_bubble", exv_v[1], 0);
    adv();
    nop();
    check("lu_sel_b", sb_v[1], 2);
    check("lu_sel_a", sa_v[1], 0);
    check("lu_ex_valid", exv_v[1], 1);
    check("lu_after_stall", stall_v[1], 0);
    adv();

    // Flush beats a pending load-use stall.
    drv(1, 0, 0, 0, 0, 7, 1, 1, 0); adv();              // lw r7
    drv(1, 0, 7, 0, 1, 9, 1, 0, 1);                     // dependent add, flushed
    check("flush_stall", stall_v[1], 0);
    adv();
    drv(1, 0, 0, 0, 0, 7, 1, 1, 0);                     // lw r7 again
    check("flush_ex_valid", exv_v[1], 0);
    check("flush_sel_a", sa_v[1], 0);
    check("flush_sel_b", sb_v[1], 0);
    adv();

    // An invalid ID slot never stalls, even with a load match.
    drv(0, 0, 7, 0, 1, 9, 1, 0, 0);
    check("invalid_no_stall", stall_v[1], 0);
    adv();
    nop(); adv();
    nop(); adv();

    // No forwarding: reader of r2 waits until the writer reaches WB.
    drv(1, 0, 0, 0, 0, 2, 1, 0, 0); adv();              // add r2
    drv(1, 2, 0, 1, 0, 10, 1, 0, 0);
    check("nofwd_stall_1", stall_v[0], 1);
    adv();
    drv(1, 2, 0, 1, 0, 10, 1, 0, 0);
    check("nofwd_stall_2", stall_v[0], 1);
    adv();
    drv(1, 2, 0, 1, 0, 10, 1, 0, 0);
    check("nofwd_stall_3", stall_v[0], 0);
    check("nofwd_wb_rd", wbrd_v[0], 2);
    check("nofwd_wb_valid", wbv_v[0], 1);
    adv();
    nop();
    check("nofwd_ex_valid", exv_v[0], 1);
    check("nofwd_sel_a", sa_v[0], 0);
    adv();

    // Reset in the middle of a load-use stall clears state at once.
    drv(1, 0, 0, 0, 0, 7, 1, 1, 0); adv();
    drv(1, 0, 7, 0, 1, 9, 1, 0, 0);
    check("midrst_stall_before", stall_v[1], 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_stall", stall_v[1], 0);
    check("midrst_ex_valid", exv_v[1], 0);
    check("midrst_stall_nofwd", stall_v[0], 0);
    adv();
    rst_n = 1'b1;
    nop(); adv();
    nop(); adv();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
